// File: rtl/mul_pkg.sv
// Shared types and constants for the signed Booth/CSA multiplier.
package mul_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned PP_ROWS = WIDTH / 2;
    localparam int unsigned PROD_W  = 2 * WIDTH;

    typedef enum logic [2:0] {
        Zero,
        Pos1,
        Pos2,
        Neg1,
        Neg2
    } booth_e;

    typedef logic [PROD_W-1:0] prod_t;

    // Radix-4 group is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_e booth_decode(input logic [2:0] grp);
        booth_e d;
        case (grp)
            3'b001, 3'b010: d = Pos1;
            3'b011:         d = Pos2;
            3'b100:         d = Neg2;
            3'b101, 3'b110: d = Neg1;
            default:        d = Zero;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial-product row: 0, +-A or +-2A as a (WIDTH+2)-bit value.
// Negative digits emit the one's complement; the +1 is returned separately via neg_o.
module booth_pp_gen
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       group_i,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH+1:0] pp_o,
    output logic             neg_o
);

    logic [WIDTH+1:0] a_ext;
    booth_e           digit;

    assign a_ext = {{2{a_i[WIDTH-1]}}, a_i};
    assign digit = booth_decode(group_i);

    always_comb begin
        pp_o  = '0;
        neg_o = 1'b0;
        unique case (digit)
            Pos1: pp_o = a_ext;
            Pos2: pp_o = a_ext << 1;
            Neg1: begin
                pp_o  = ~a_ext;
                neg_o = 1'b1;
            end
            Neg2: begin
                pp_o  = ~(a_ext << 1);
                neg_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/top.sv
// Signed WIDTHxWIDTH -> 2*WIDTH multiplier: Booth rows, CSA reduction, final adder, registered out.
// Define MUL_PIPE_EN to register the two CSA vectors as well (latency 2).
module top
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] out
);

    localparam int unsigned Rows  = WIDTH / 2;
    localparam int unsigned ProdW = 2 * WIDTH;

    logic [WIDTH:0]   b_ext;
    logic [WIDTH+1:0] pp   [Rows];
    logic [ProdW-1:0] row  [Rows];
    logic [Rows-1:0]  neg;
    logic [ProdW-1:0] corr;
    logic [ProdW-1:0] sum_v, carry_v, tmp_v;
    logic [ProdW-1:0] out_d, out_q;

    assign b_ext = {multiplier, 1'b0};

    for (genvar i = 0; i < Rows; i++) begin : g_row
        booth_pp_gen #(
            .WIDTH(WIDTH)
        ) u_pp (
            .group_i(b_ext[2*i+2:2*i]),
            .a_i    (multiplicand),
            .pp_o   (pp[i]),
            .neg_o  (neg[i])
        );
        assign row[i] = {{(ProdW-WIDTH-2){pp[i][WIDTH+1]}}, pp[i]} << (2 * i);
    end

    // Negation correction bits never collide, so they share a single addend.
    always_comb begin
        corr = '0;
        for (int i = 0; i < Rows; i++) begin
            corr[2*i] = neg[i];
        end
    end

    always_comb begin
        sum_v   = row[0];
        carry_v = row[1];
        tmp_v   = '0;
        for (int i = 2; i < Rows; i++) begin
            tmp_v   = sum_v ^ carry_v ^ row[i];
            carry_v = ((sum_v & carry_v) | (sum_v & row[i]) | (carry_v & row[i])) << 1;
            sum_v   = tmp_v;
        end
        tmp_v   = sum_v ^ carry_v ^ corr;
        carry_v = ((sum_v & carry_v) | (sum_v & corr) | (carry_v & corr)) << 1;
        sum_v   = tmp_v;
    end

`ifdef MUL_PIPE_EN
    logic [ProdW-1:0] sum_q, carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            sum_q   <= sum_v;
            carry_q <= carry_v;
        end
    end

    assign out_d = sum_q + carry_q;
`else
    assign out_d = sum_v + carry_v;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_top.sv
// Directed and random checks of the signed multiplier, latency-aware for MUL_PIPE_EN.
module tb_top;

`ifdef MUL_PIPE_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic [63:0] out;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [31:0] va[$];
    logic [31:0] vb[$];
    logic [63:0] ve[$];

    logic signed [63:0] sa, sb;
    logic [31:0]        ra, rb;

    always #5 clk = ~clk;

    top #(
        .WIDTH(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .multiplicand(a),
        .multiplier  (b),
        .out         (out)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] x, input logic [31:0] y, input logic [63:0] e);
        va.push_back(x);
        vb.push_back(y);
        ve.push_back(e);
    endtask

    initial begin
        rst_n = 1'b1;
        a     = 32'd5;
        b     = 32'd7;

        #2 rst_n = 1'b0;
        #1 check_eq("rst_async", out, 64'h0);
        @(posedge clk); #1;
        check_eq("rst_hold", out, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef MUL_PIPE_EN
        @(posedge clk); #1;
        check_eq("pipe_fill", out, 64'h0);
`endif
        @(posedge clk); #1;
        check_eq("first_prod", out, 64'd35);

        // Reset in the middle of a cycle with a new product in flight.
        @(negedge clk);
        a = 32'h1;
        b = 32'h4D75B3D1;
        #2 rst_n = 1'b0;
        #1 check_eq("rst_mid", out, 64'h0);
        @(posedge clk); #1;
        check_eq("rst_mid_hold", out, 64'h0);

        add_vec(32'h00000005, 32'h00000007, 64'h0000000000000023);
        add_vec(32'h00000001, 32'h4D75B3D1, 64'h000000004D75B3D1);
        add_vec(32'hFFFFFFFF, 32'h7FFFFFFF, 64'hFFFFFFFF80000001);
        add_vec(32'h80000000, 32'h80000000, 64'h4000000000000000);
        add_vec(32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000);
        add_vec(32'h00000001, 32'h4D75B3DB, 64'h000000004D75B3DB);
        add_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001);
        add_vec(32'h00000000, 32'h12345678, 64'h0000000000000000);
        add_vec(32'hDEADBEEF, 32'h00000000, 64'h0000000000000000);
        add_vec(32'h12345678, 32'hFFFFFFFF, 64'hFFFFFFFFEDCBA988);
        add_vec(32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000);
        add_vec(32'hFFFFFFFF, 32'h80000000, 64'h0000000080000000);
        add_vec(32'h00010000, 32'h00010000, 64'h0000000100000000);
        add_vec(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001);
        add_vec(32'h00000003, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFF7);
        for (int r = 0; r < 300; r++) begin
            ra = $urandom;
            rb = $urandom;
            if (r % 10 == 0) ra = 32'h0;
            if (r % 10 == 5) rb = 32'h0;
            sa = {{32{ra[31]}}, ra};
            sb = {{32{rb[31]}}, rb};
            add_vec(ra, rb, sa * sb);
        end

        // Back-to-back stream; operands are scrambled after each edge to prove only edges sample.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < va.size() + Lat - 1; k++) begin
            if (k < va.size()) begin
                a = va[k];
                b = vb[k];
            end
            @(posedge clk); #1;
`ifdef MUL_PIPE_EN
            if (k == 0) check_eq("pipe_first", out, 64'h0);
`endif
            if (k >= Lat - 1) check_eq($sformatf("vec%0d", k - Lat + 1), out, ve[k-Lat+1]);
            a = $urandom;
            b = $urandom;
            #2;
            if (k >= Lat - 1) check_eq($sformatf("hold%0d", k - Lat + 1), out, ve[k-Lat+1]);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
